// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Debounces a raw, bouncing, low-active push button and turns it into a clean
// high-active level plus one-cycle strobes for press, release and long hold.
// The raw input is first brought into the clock domain through a two-flop
// synchronizer. A four-state FSM then requires DEBOUNCE_CYCLES of stable
// input before it accepts a press or a release. While a press is held, a
// saturating hold counter fires long_pulse once after LONG_CYCLES.
//
// Parameters
//   DEBOUNCE_CYCLES  stable-input time needed to accept a press/release (>= 2)
//   LONG_CYCLES      accepted-press hold time that fires long_pulse     (>= 1)
//
// Ports
//   clk            in   1  system clock, all state updates on rising edge
//   rst            in   1  synchronous, active-high reset
//   btnx           in   1  raw asynchronous button, 0 = pushed
//   btn_level      out  1  debounced button state, 1 = pressed
//   press_pulse    out  1  one-cycle strobe when a press is accepted
//   release_pulse  out  1  one-cycle strobe when a release is accepted
//   long_pulse     out  1  one-cycle strobe after LONG_CYCLES of accepted hold
//   press_count    out  8  accepted presses, modulo 256
// -----------------------------------------------------------------------------
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 240_000,
   parameter int unsigned LONG_CYCLES     = 24_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnx,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   // Counters are just wide enough to hold their parameter value.
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   logic              r_sync1;
   logic              r_sync2;
   state_t            r_state;
   logic [DB_W-1:0]   r_db_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_long_fired;
   logic              r_btn_level;
   logic              r_press_pulse;
   logic              r_release_pulse;
   logic              r_long_pulse;
   logic [7:0]        r_press_count;

   // --------------------------------------------------------------------------
   // Next-state wires
   // --------------------------------------------------------------------------
   logic              w_pressed;
   state_t            w_state_next;
   logic [DB_W-1:0]   w_db_cnt_next;
   logic [HOLD_W-1:0] w_hold_cnt_next;
   logic [HOLD_W-1:0] w_hold_inc;
   logic              w_long_fired_next;
   logic              w_btn_level_next;
   logic              w_press_pulse_next;
   logic              w_release_pulse_next;
   logic              w_long_pulse_next;
   logic [7:0]        w_press_count_next;

   // --------------------------------------------------------------------------
   // Two-flop synchronizer. Both flops reset to 1 so that reset looks like a
   // released button and a held button must be debounced again afterwards.
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its source; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= btnx;
         r_sync2 <= r_sync1;
      end
   end

   // Button is low active on the pin; internally 1 means pushed.
   assign w_pressed = ~r_sync2;

   // Saturating increment of the hold counter; it never wraps back to zero,
   // so a long_pulse cannot be re-armed by a counter overflow.
   assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt
                                                : r_hold_cnt + HOLD_W'(1);

   // --------------------------------------------------------------------------
   // FSM next-state and next-output logic
   // --------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_next         = r_state;
      w_db_cnt_next        = r_db_cnt;
      w_hold_cnt_next      = r_hold_cnt;
      w_long_fired_next    = r_long_fired;
      w_btn_level_next     = r_btn_level;
      w_press_pulse_next   = 1'b0;
      w_release_pulse_next = 1'b0;
      w_long_pulse_next    = 1'b0;
      w_press_count_next   = r_press_count;

      case (r_state)
         IDLE: begin
            if (w_pressed) begin
               w_state_next  = PRESS_WAIT;
               w_db_cnt_next = '0;
            end
         end

         PRESS_WAIT: begin
            if (!w_pressed) begin
               // Bounce: drop back without any strobe.
               w_state_next  = IDLE;
               w_db_cnt_next = '0;
            end else if (r_db_cnt == DB_LAST) begin
               // Input has been stable long enough: accept the press.
               w_state_next       = PRESSED;
               w_db_cnt_next      = '0;
               w_btn_level_next   = 1'b1;
               w_press_pulse_next = 1'b1;
               w_press_count_next = r_press_count + 8'd1;
               w_hold_cnt_next    = '0;
               w_long_fired_next  = 1'b0;
            end else begin
               w_db_cnt_next = r_db_cnt + DB_W'(1);
            end
         end

         PRESSED: begin
            // The hold counter only advances here. Keeping long_pulse out of
            // RELEASE_WAIT guarantees it never coincides with release_pulse.
            w_hold_cnt_next = w_hold_inc;
            if ((w_hold_inc == HOLD_MAX) && !r_long_fired) begin
               w_long_pulse_next = 1'b1;
               w_long_fired_next = 1'b1;
            end
            if (!w_pressed) begin
               w_state_next  = RELEASE_WAIT;
               w_db_cnt_next = '0;
            end
         end

         RELEASE_WAIT: begin
            if (w_pressed) begin
               // Release bounce: resume the press as if nothing happened;
               // hold counter and long-fired flag carry over.
               w_state_next  = PRESSED;
               w_db_cnt_next = '0;
            end else if (r_db_cnt == DB_LAST) begin
               w_state_next         = IDLE;
               w_db_cnt_next        = '0;
               w_btn_level_next     = 1'b0;
               w_release_pulse_next = 1'b1;
            end else begin
               w_db_cnt_next = r_db_cnt + DB_W'(1);
            end
         end

         default: begin
            w_state_next  = IDLE;
            w_db_cnt_next = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM state and registered outputs. Reset wins over every state, and since
   // it forces all strobes low a reset while pressed never emits a release.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_db_cnt        <= '0;
         r_hold_cnt      <= '0;
         r_long_fired    <= 1'b0;
         r_btn_level     <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;
         r_press_count   <= 8'h00;
      end else begin
         r_state         <= w_state_next;
         r_db_cnt        <= w_db_cnt_next;
         r_hold_cnt      <= w_hold_cnt_next;
         r_long_fired    <= w_long_fired_next;
         r_btn_level     <= w_btn_level_next;
         r_press_pulse   <= w_press_pulse_next;
         r_release_pulse <= w_release_pulse_next;
         r_long_pulse    <= w_long_pulse_next;
         r_press_count   <= w_press_count_next;
      end
   end

   assign btn_level     = r_btn_level;
   assign press_pulse   = r_press_pulse;
   assign release_pulse = r_release_pulse;
   assign long_pulse    = r_long_pulse;
   assign press_count   = r_press_count;

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Stimulus pushes each expected strobe (kind, cycle, count, level) into a
// queue when it drives btnx; an independent monitor pops and compares every
// time the DUT raises a strobe. Level/count checks between scenarios are
// made directly.
//
// Timing used for expectations: btnx changes on a falling edge when the edge
// counter reads c; the change is first sampled at rising edge c+1, so an
// accepted press/release strobe is seen on the falling edge where cyc = c+7,
// and a long_pulse 20 cycles after its press strobe.
// -----------------------------------------------------------------------------
module tb_button_debounce;

   localparam int DB   = 4;
   localparam int LONG = 20;

   localparam logic [2:0] K_PRESS = 3'b100;
   localparam logic [2:0] K_REL   = 3'b010;
   localparam logic [2:0] K_LONG  = 3'b001;

   typedef struct {
      logic [2:0] kind;
      int         cyc;
      logic [7:0] cnt;
      logic       lvl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       btnx;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic [7:0] press_count;

   int         cyc = 0;
   int         n_vec = 0;
   int         n_miss = 0;
   logic [7:0] exp_count = 8'h00;
   exp_t       q[$];
   exp_t       e;

   button_debounce #(
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES    (LONG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btnx         (btnx),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .press_count  (press_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] kind, input int at, input logic [7:0] cnt,
                       input logic lvl);
      exp_t x;
      x.kind = kind;
      x.cyc  = at;
      x.cnt  = cnt;
      x.lvl  = lvl;
      q.push_back(x);
   endtask

   // Called on a falling edge: push btnx low for low_n cycles.
   task automatic press_hold(input int low_n, input bit exp_long);
      exp_count = exp_count + 8'd1;
      push(K_PRESS, cyc + DB + 3, exp_count, 1'b1);
      if (exp_long) push(K_LONG, cyc + DB + 3 + LONG, exp_count, 1'b1);
      btnx = 1'b0;
      repeat (low_n) @(negedge clk);
   endtask

   // Called on a falling edge: release btnx for high_n cycles.
   task automatic release_hold(input int high_n);
      push(K_REL, cyc + DB + 3, exp_count, 1'b0);
      btnx = 1'b1;
      repeat (high_n) @(negedge clk);
   endtask

   // Scoreboard monitor: every strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (press_pulse || release_pulse || long_pulse) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", {press_pulse, release_pulse, long_pulse}, 0);
         end else begin
            e = q.pop_front();
            check("pulse_kind",  {press_pulse, release_pulse, long_pulse}, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_count", press_count, e.cnt);
            check("pulse_level", btn_level, e.lvl);
         end
      end
   end

   initial begin
      rst  = 1'b1;
      btnx = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_level",   btn_level, 0);
      check("rst_press",   press_pulse, 0);
      check("rst_release", release_pulse, 0);
      check("rst_long",    long_pulse, 0);
      check("rst_count",   press_count, 8'h00);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean press, 10 cycles low.
      press_hold(10, 1'b0);
      check("clean_level", btn_level, 1);
      check("clean_count", press_count, exp_count);
      release_hold(10);
      check("clean_rel_level", btn_level, 0);

      // Bounce reject: low 3, high 1, low 3, high.
      btnx = 1'b0; repeat (3) @(negedge clk);
      btnx = 1'b1; repeat (1) @(negedge clk);
      btnx = 1'b0; repeat (3) @(negedge clk);
      btnx = 1'b1; repeat (10) @(negedge clk);
      check("bounce_level", btn_level, 0);
      check("bounce_count", press_count, exp_count);

      // Long hold: one press, one long, then quiet until release.
      press_hold(40, 1'b1);
      check("long_level", btn_level, 1);
      release_hold(10);
      check("long_rel_level", btn_level, 0);

      // Release bounce while pressed.
      press_hold(10, 1'b0);
      btnx = 1'b1; repeat (2) @(negedge clk);
      btnx = 1'b0; repeat (5) @(negedge clk);
      check("relbounce_level", btn_level, 1);
      check("relbounce_count", press_count, exp_count);
      release_hold(10);

      // 256 press/release cycles bring the count back around.
      for (int i = 0; i < 256; i++) begin
         press_hold(8, 1'b0);
         release_hold(8);
      end
      check("wrap_count", press_count, exp_count);
      check("wrap_level", btn_level, 0);

      // Bring the count to 0x05 and hold in PRESSED.
      press_hold(10, 1'b0);
      release_hold(10);
      press_hold(12, 1'b0);
      check("pre_rst_count", press_count, 8'h05);
      check("pre_rst_level", btn_level, 1);

      // One-cycle reset while pressed; btnx stays low.
      rst = 1'b1;
      exp_count = 8'h01;
      push(K_PRESS, cyc + DB + 4, exp_count, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_level",   btn_level, 0);
      check("midrst_press",   press_pulse, 0);
      check("midrst_release", release_pulse, 0);
      check("midrst_long",    long_pulse, 0);
      check("midrst_count",   press_count, 8'h00);
      repeat (12) @(negedge clk);
      check("after_rst_level", btn_level, 1);
      check("after_rst_count", press_count, exp_count);
      release_hold(10);

      repeat (5) @(negedge clk);
      check("pending_expectations", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
